// File: rtl/rx_page_reader_if.sv
// Bundles the page reader's RAM read port and its packet byte stream.
// Latency: none, wires only.
// Backpressure: out_ready from the byte sink stalls the stream; the RAM port has no flow control.
interface rx_page_reader_if;
    logic [7:0]  mem_rd_addr;
    logic [47:0] mem_rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;

    // Page reader side: drives the RAM address and the byte stream
    modport master (
        output mem_rd_addr,
        input  mem_rd_data,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_sop,
        output out_eop
    );

    // RAM / byte sink side
    modport slave (
        input  mem_rd_addr,
        output mem_rd_data,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_sop,
        input  out_eop
    );
endinterface

// File: rtl/rx_page_reader.sv
// Frames each completed ping-pong RAM page as a 20-byte header + 6*WORDS payload byte packet.
// Latency: header byte 0 valid 2 clocks after the page toggle; RAM_LAT+1 dead clocks before each payload word.
// Backpressure: out_ready stalls the stream with byte/sop/eop held; mid-packet toggles queue (newest wins) as overruns.
// Optional feature macro RX_OVR_CNT_EN: saturating 16-bit overrun counter on port ovr_cnt and in header bytes 8-9.
module rx_page_reader #(
    parameter int WORDS   = 82,
    parameter int RAM_LAT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr_block,
    rx_page_reader_if.master bus,
    output logic             busy
`ifdef RX_OVR_CNT_EN
    ,
    output logic [15:0]      ovr_cnt
`endif
);

    localparam logic [6:0] LAST_WORD  = 7'(WORDS - 1);
    localparam logic [1:0] LAT_CNT    = 2'(RAM_LAT);
    localparam logic [4:0] HDR_LAST   = 5'd19;
    localparam logic [4:0] WORD_LAST  = 5'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic        pending_q, pending_d;
    logic        pend_page_q, pend_page_d;
    logic        ovr_flag_q, ovr_flag_d;
    logic        page_q, page_d;
    logic        hdr_ovr_q, hdr_ovr_d;
    logic [4:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]  word_q, word_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [47:0] shift_q, shift_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] seq_q, seq_d;
    logic        busy_q, busy_d;
`ifdef RX_OVR_CNT_EN
    logic [15:0] ovr_cnt_q, ovr_cnt_d;
    logic [15:0] hdr_cnt_q, hdr_cnt_d;
`endif

    logic        toggle;
    logic        start;
    logic        overrun;
    logic        accept;
    logic        out_valid_w;
    logic [7:0]  hdr_byte;

    // A page is taken from the pending slot only when the FSM sits idle
    assign start  = (state_q == ST_IDLE) && pending_q;
    assign toggle = (wr_q != wr_block);
    assign accept = out_valid_w && bus.out_ready;

    // Page toggle tracking: newest completed page wins, any toggle while a page is owed is an overrun
    always_comb begin
        wr_d        = wr_block;
        pending_d   = pending_q;
        pend_page_d = pend_page_q;
        ovr_flag_d  = ovr_flag_q;
        overrun     = 1'b0;
        if (start) begin
            pending_d  = 1'b0;
            ovr_flag_d = 1'b0;
        end
        if (toggle && enable) begin
            pending_d   = 1'b1;
            pend_page_d = wr_block;
            if ((state_q != ST_IDLE) || pending_q) begin
                overrun    = 1'b1;
                ovr_flag_d = 1'b1;
            end
        end
    end

`ifdef RX_OVR_CNT_EN
    // Overrun event counter, sticks at all-ones until reset
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (overrun && (ovr_cnt_q != 16'hFFFF)) begin
            ovr_cnt_d = ovr_cnt_q + 16'd1;
        end
    end
`endif

    // Packet sequencer: header bytes, then per word a RAM fetch, a latency wait and six byte sends
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        hdr_ovr_d  = hdr_ovr_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        wait_cnt_d = wait_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        seq_d      = seq_q;
`ifdef RX_OVR_CNT_EN
        hdr_cnt_d  = hdr_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    page_d     = pend_page_q;
                    hdr_ovr_d  = ovr_flag_q;
`ifdef RX_OVR_CNT_EN
                    hdr_cnt_d  = ovr_cnt_q;
`endif
                    byte_cnt_d = 5'd0;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    if (byte_cnt_q == HDR_LAST) begin
                        byte_cnt_d = 5'd0;
                        word_d     = 7'd0;
                        addr_d     = {page_q, 7'd0};
                        state_d    = ST_FETCH;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                    end
                end
            end
            ST_FETCH: begin
                wait_cnt_d = 2'd1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == LAT_CNT) begin
                    shift_d    = bus.mem_rd_data;
                    byte_cnt_d = 5'd0;
                    state_d    = ST_SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    shift_d = {shift_q[39:0], 8'h00};
                    if (byte_cnt_q == WORD_LAST) begin
                        byte_cnt_d = 5'd0;
                        if (word_q == LAST_WORD) begin
                            state_d = ST_DONE;
                        end else begin
                            word_d  = word_q + 7'd1;
                            addr_d  = {page_q, word_q + 7'd1};
                            state_d = ST_FETCH;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                seq_d   = seq_q + 32'd1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Header byte select from the values captured when the packet started
    always_comb begin
        hdr_byte = 8'h00;
        case (byte_cnt_q)
            5'd0:  hdr_byte = 8'hEF;
            5'd1:  hdr_byte = 8'hFE;
            5'd2:  hdr_byte = 8'h01;
            5'd3:  hdr_byte = {7'b0, page_q};
            5'd4:  hdr_byte = seq_q[31:24];
            5'd5:  hdr_byte = seq_q[23:16];
            5'd6:  hdr_byte = seq_q[15:8];
            5'd7:  hdr_byte = seq_q[7:0];
`ifdef RX_OVR_CNT_EN
            5'd8:  hdr_byte = hdr_cnt_q[15:8];
            5'd9:  hdr_byte = hdr_cnt_q[7:0];
`endif
            5'd10: hdr_byte = {7'b0, hdr_ovr_q};
            default: hdr_byte = 8'h00;
        endcase
    end

    // Stream outputs decode only registered state, so they cannot move during a stall
    always_comb begin
        out_valid_w   = (state_q == ST_HDR) || (state_q == ST_SEND);
        bus.out_data  = (state_q == ST_HDR) ? hdr_byte : shift_q[47:40];
        bus.out_sop   = (state_q == ST_HDR) && (byte_cnt_q == 5'd0);
        bus.out_eop   = (state_q == ST_SEND) && (word_q == LAST_WORD) && (byte_cnt_q == WORD_LAST);
    end

    assign bus.out_valid   = out_valid_w;
    assign bus.mem_rd_addr = addr_q;
    assign busy            = busy_q;
`ifdef RX_OVR_CNT_EN
    assign ovr_cnt         = ovr_cnt_q;
`endif

    // State registers; reset aborts any packet and re-aligns the toggle detector to the current page
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_q        <= wr_block;
            pending_q   <= 1'b0;
            pend_page_q <= 1'b0;
            ovr_flag_q  <= 1'b0;
            page_q      <= 1'b0;
            hdr_ovr_q   <= 1'b0;
            byte_cnt_q  <= 5'd0;
            word_q      <= 7'd0;
            wait_cnt_q  <= 2'd0;
            shift_q     <= 48'd0;
            addr_q      <= 8'd0;
            seq_q       <= 32'd0;
            busy_q      <= 1'b0;
`ifdef RX_OVR_CNT_EN
            ovr_cnt_q   <= 16'd0;
            hdr_cnt_q   <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            pending_q   <= pending_d;
            pend_page_q <= pend_page_d;
            ovr_flag_q  <= ovr_flag_d;
            page_q      <= page_d;
            hdr_ovr_q   <= hdr_ovr_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            wait_cnt_q  <= wait_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            seq_q       <= seq_d;
            busy_q      <= busy_d;
`ifdef RX_OVR_CNT_EN
            ovr_cnt_q   <= ovr_cnt_d;
            hdr_cnt_q   <= hdr_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_rx_page_reader.sv
// Bench for rx_page_reader: RAM model, byte-stream monitor, packet-level reference model.
// Directed tables for header/overrun cases, randomized pages, backpressure and toggle timing.
// Works with and without RX_OVR_CNT_EN.
module tb_rx_page_reader;
    localparam int WORDS   = 82;
    localparam int LAT     = 2;
    localparam int PKT_LEN = 20 + 6 * WORDS;

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic enable   = 1'b0;
    logic wr_block = 1'b0;
    logic ready    = 1'b1;
    logic busy;
`ifdef RX_OVR_CNT_EN
    logic [15:0] ovr_cnt;
`endif
    int ready_pct = 100;

    rx_page_reader_if bus ();

    rx_page_reader #(.WORDS(WORDS), .RAM_LAT(LAT)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .wr_block (wr_block),
        .bus      (bus),
        .busy     (busy)
`ifdef RX_OVR_CNT_EN
        ,
        .ovr_cnt  (ovr_cnt)
`endif
    );

    always #5 clock = ~clock;

    // RAM port B: data appears LAT clocks after the address
    logic [47:0] mem [256];
    logic [47:0] rd_pipe [LAT];
    always @(posedge clock) begin
        rd_pipe[0] <= mem[bus.mem_rd_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rd_data = rd_pipe[LAT-1];
    assign bus.out_ready   = ready;

    typedef struct packed { logic [7:0] d; logic sop; logic eop; } beat_t;
    beat_t      rx_q[$];
    beat_t      exp_q[$];
    logic [7:0] addr_log[$];
    logic [7:0] last_addr;
    int total = 0;
    int bad   = 0;

    // Sink readiness, changed just after each rising edge
    initial forever begin
        @(posedge clock); #1;
        ready = ($urandom_range(99, 0) < ready_pct);
    end

    // Monitor on the falling edge: record transfers, check stalled bytes are held, log address changes
    logic  stall_prev = 1'b0;
    beat_t stall_beat;
    initial forever begin
        @(negedge clock);
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                total++;
                if (!bus.out_valid || ({bus.out_data, bus.out_sop, bus.out_eop} != stall_beat)) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%0b beat=%h required valid=1 beat=%h",
                             bus.out_valid, {bus.out_data, bus.out_sop, bus.out_eop}, stall_beat);
                end
            end
            if (bus.out_valid && bus.out_ready) rx_q.push_back({bus.out_data, bus.out_sop, bus.out_eop});
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_beat = {bus.out_data, bus.out_sop, bus.out_eop};
        end
        if (bus.mem_rd_addr !== last_addr) begin
            addr_log.push_back(bus.mem_rd_addr);
            last_addr = bus.mem_rd_addr;
        end
    end

    // Packet-level reference model
    logic [31:0] exp_seq  = 32'd0;
    int          exp_cnt  = 0;
    bit          m_pend   = 1'b0;
    bit          m_page   = 1'b0;
    bit          m_ovr    = 1'b0;

    function automatic void push_pkt(input bit page, input bit ovr);
        logic [7:0]  h [20];
        logic [47:0] wd;
        logic [15:0] c;
        for (int i = 0; i < 20; i++) h[i] = 8'h00;
        c     = 16'(exp_cnt);
        h[0]  = 8'hEF;
        h[1]  = 8'hFE;
        h[2]  = 8'h01;
        h[3]  = {7'b0, page};
        h[4]  = exp_seq[31:24];
        h[5]  = exp_seq[23:16];
        h[6]  = exp_seq[15:8];
        h[7]  = exp_seq[7:0];
`ifdef RX_OVR_CNT_EN
        h[8]  = c[15:8];
        h[9]  = c[7:0];
`endif
        h[10] = {7'b0, ovr};
        for (int i = 0; i < 20; i++) exp_q.push_back({h[i], (i == 0), 1'b0});
        for (int w = 0; w < WORDS; w++) begin
            wd = mem[{page, 7'(w)}];
            for (int b = 0; b < 6; b++)
                exp_q.push_back({wd[47 - 8*b -: 8], 1'b0, ((w == WORDS - 1) && (b == 5))});
        end
        exp_seq = exp_seq + 32'd1;
    endfunction

    function automatic void model_toggle(input bit page, input bit en, input bit mid);
        if (en) begin
            if (mid || m_pend) begin
                m_ovr = 1'b1;
                if (exp_cnt < 65535) exp_cnt++;
            end
            m_pend = 1'b1;
            m_page = page;
        end
    endfunction

    function automatic void model_start();
        if (m_pend) begin
            push_pkt(m_page, m_ovr);
            m_pend = 1'b0;
            m_ovr  = 1'b0;
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, want);
        end
    endtask

    task automatic drive_toggle(input bit mid);
        wr_block = ~wr_block;
        model_toggle(wr_block, enable, mid);
        cyc(1);
    endtask

    task automatic wait_rx(input int n, input string name);
        int k = 0;
        while ((rx_q.size() < n) && (k < 20000)) begin cyc(1); k++; end
        if (rx_q.size() < n) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d bytes required %0d", name, rx_q.size(), n);
        end
    endtask

    task automatic check_stream(input string name);
        int np;
        int first;
        np = exp_q.size() / PKT_LEN;
        chk({name, "_len"}, rx_q.size(), exp_q.size());
        for (int p = 0; p < np; p++) begin
            first = -1;
            for (int i = p * PKT_LEN; i < (p + 1) * PKT_LEN; i++)
                if ((first < 0) && ((i >= rx_q.size()) || (rx_q[i] !== exp_q[i]))) first = i;
            total++;
            if (first >= 0) begin
                bad++;
                if (first < rx_q.size())
                    $display("FAIL %s_pkt%0d: byte %0d got %h required %h", name, p, first, rx_q[first], exp_q[first]);
                else
                    $display("FAIL %s_pkt%0d: byte %0d missing, required %h", name, p, first, exp_q[first]);
            end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    typedef struct { int idx; logic [7:0] want; } hvec_t;
    typedef struct { int rpct; int tog_a; int tog_b; int pkts; logic [7:0] ovr; logic [15:0] cnt; } vec_t;
    hvec_t htab [14];
    vec_t  vtab [4];

    initial begin : main
        logic [7:0]  ab;
        logic [63:0] rnd;
        logic [15:0] want_cnt;
        int nsop, base, nx, neop;
        int pos [2];
        bit ok;

        htab[0]  = '{0,   8'hEF}; htab[1]  = '{1,   8'hFE}; htab[2]  = '{2,   8'h01};
        htab[3]  = '{3,   8'h01}; htab[4]  = '{4,   8'h00}; htab[5]  = '{7,   8'h00};
        htab[6]  = '{8,   8'h00}; htab[7]  = '{9,   8'h00}; htab[8]  = '{10,  8'h00};
        htab[9]  = '{19,  8'h00}; htab[10] = '{20,  8'h80}; htab[11] = '{25,  8'h80};
        htab[12] = '{26,  8'h81}; htab[13] = '{511, 8'hD1};
        vtab[0]  = '{50,  100, 300, 2, 8'h01, 16'd2};
        vtab[1]  = '{100, -1,  -1,  1, 8'h00, 16'd2};
        vtab[2]  = '{70,  250, -1,  2, 8'h01, 16'd3};
        vtab[3]  = '{100, 20,  -1,  2, 8'h01, 16'd4};

        for (int a = 0; a < 256; a++) begin ab = 8'(a); mem[a] = {6{ab}}; end

        // Reset held three clocks
        reset = 1'b1;
        cyc(3);
        @(negedge clock);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_addr",  32'(bus.mem_rd_addr), 0);
        chk("rst_sop_eop", {30'd0, bus.out_sop, bus.out_eop}, 0);
        cyc(1);
        reset = 1'b0;
        enable = 1'b1;
        cyc(2);

        // Page 1 with sink always ready
        addr_log.delete();
        ready_pct = 100;
        drive_toggle(1'b0);
        model_start();
        wait_rx(100, "t2a");
        chk("t2_busy_mid", 32'(busy), 1);
        wait_rx(PKT_LEN, "t2");
        cyc(40);
        chk("t2_busy_end", 32'(busy), 0);
        for (int i = 0; i < 14; i++)
            if (htab[i].idx < rx_q.size()) chk($sformatf("t2_byte%0d", htab[i].idx), 32'(rx_q[htab[i].idx].d), 32'(htab[i].want));
        ok = (addr_log.size() == WORDS);
        for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] !== 8'(8'h80 + i)) ok = 1'b0;
        chk("t2_addr_seq", 32'(ok), 1);
        check_stream("t2");

        // Page 0 with random backpressure
        ready_pct = 50;
        drive_toggle(1'b0);
        model_start();
        wait_rx(PKT_LEN, "t3");
        cyc(40);
        check_stream("t3");

        // Overrun scenarios
        for (int v = 0; v < 4; v++) begin
            ready_pct = vtab[v].rpct;
            drive_toggle(1'b0);
            model_start();
            if (vtab[v].tog_a >= 0) begin wait_rx(vtab[v].tog_a, "ovr_a"); drive_toggle(1'b1); end
            if (vtab[v].tog_b >= 0) begin wait_rx(vtab[v].tog_b, "ovr_b"); drive_toggle(1'b1); end
            wait_rx(PKT_LEN, "ovr1");
            model_start();
            wait_rx(exp_q.size(), "ovr2");
            cyc(40);
            nsop = 0;
            for (int i = 0; i < rx_q.size(); i++) if (rx_q[i].sop) nsop++;
            chk($sformatf("vec%0d_pkts", v), nsop, vtab[v].pkts);
`ifdef RX_OVR_CNT_EN
            want_cnt = vtab[v].cnt;
`else
            want_cnt = 16'h0000;
`endif
            base = (nsop > 0) ? (nsop - 1) * PKT_LEN : 0;
            if (base + 10 < rx_q.size()) begin
                chk($sformatf("vec%0d_ovr", v), 32'(rx_q[base+10].d), 32'(vtab[v].ovr));
                chk($sformatf("vec%0d_cnt", v), {16'd0, rx_q[base+8].d, rx_q[base+9].d}, 32'(want_cnt));
            end
            check_stream($sformatf("vec%0d", v));
        end
`ifdef RX_OVR_CNT_EN
        chk("ovr_cnt_port", 32'(ovr_cnt), 32'(exp_cnt));
`endif

        // Disabled toggles are ignored; disabling mid-packet lets the packet finish
        ready_pct = 100;
        enable = 1'b0;
        for (int t = 0; t < 3; t++) begin drive_toggle(1'b0); cyc(10); end
        cyc(100);
        chk("t5_no_pkt", rx_q.size(), 0);
        chk("t5_idle", 32'(busy), 0);
        enable = 1'b1;
        drive_toggle(1'b0);
        model_start();
        wait_rx(50, "t5a");
        enable = 1'b0;
        wait_rx(PKT_LEN, "t5");
        cyc(40);
        check_stream("t5");
        enable = 1'b1;

        // Randomized pages, backpressure and late toggles (some with enable low)
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 256; a++) begin
                rnd = {$urandom(), $urandom()};
                mem[a] = rnd[47:0];
            end
            ready_pct = $urandom_range(100, 30);
            drive_toggle(1'b0);
            model_start();
            nx = $urandom_range(2, 0);
            pos[0] = $urandom_range(200, 5);
            pos[1] = $urandom_range(505, 250);
            for (int j = 0; j < nx; j++) begin
                wait_rx(pos[j], "rnd_pos");
                enable = 1'($urandom_range(1, 0));
                drive_toggle(1'b1);
                enable = 1'b1;
            end
            wait_rx(PKT_LEN, "rnd1");
            model_start();
            wait_rx(exp_q.size(), "rnd2");
            cyc(40);
            check_stream($sformatf("rnd%0d", r));
        end

        // Reset in the middle of a packet
        ready_pct = 100;
        drive_toggle(1'b0);
        model_start();
        wait_rx(200, "t6");
        reset = 1'b1;
        cyc(1);
        @(negedge clock);
        chk("t6_valid_drop", 32'(bus.out_valid), 0);
        neop = 0;
        ok = 1'b1;
        for (int i = 0; i < rx_q.size(); i++) begin
            if (rx_q[i].eop) neop++;
            if ((i >= exp_q.size()) || (rx_q[i] !== exp_q[i])) ok = 1'b0;
        end
        chk("t6_no_eop", neop, 0);
        chk("t6_short", 32'(rx_q.size() < PKT_LEN), 1);
        chk("t6_prefix", 32'(ok), 1);
        rx_q.delete();
        exp_q.delete();
        exp_seq = 32'd0;
        exp_cnt = 0;
        m_pend  = 1'b0;
        m_ovr   = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        drive_toggle(1'b0);
        model_start();
        wait_rx(PKT_LEN, "t6b");
        cyc(40);
        check_stream("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
